// File: rtl/usb_pkt_rx.sv
// USB packet receive decoder. Sits behind the SIE receive side: checks the
// PID, parses token/SOF fields, verifies CRC5/CRC16, streams the data payload
// with the CRC bytes stripped and reports end-of-packet status.
module usb_pkt_rx #(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_active,
    input  logic        rx_error,
    input  logic [6:0]  dev_addr,
    output logic [3:0]  pid,
    output logic        token_valid,
    output logic [3:0]  token_ep,
    output logic        sof_valid,
    output logic [10:0] frame_num,
    output logic        hsk_valid,
    output logic        data_start,
    output logic [7:0]  data_byte,
    output logic        data_valid,
    output logic        data_done,
    output logic        data_ok,
    output logic        pkt_err
);
    // Byte counter must reach MAX_PAYLOAD + 2 (payload plus CRC16 bytes).
    localparam int CW = $clog2(MAX_PAYLOAD + 3);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_TWO = CW'(2);
    localparam logic [CW-1:0] CNT_LIM = CW'(MAX_PAYLOAD + 2);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSK, S_DRAIN} state_t;

    state_t state, state_nxt;

    logic          act_q, end_pend;
    logic          err_flag, is_data;
    logic [CW-1:0] cnt;
    logic [4:0]    crc5;
    logic [15:0]   crc16;
    logic [7:0]    b1, d0, d1;
    logic [2:0]    b2;

    logic rise, fall, byte_in, pid_is_data, start;
    logic set_err, pid_take, tok_take, dat_take, emit;
    logic dat_good;

    // Serial CRC5 (x^5+x^2+1), LSB of the byte first.
    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        logic       fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[4] ^ d[i];
            r  = {r[3:0], 1'b0};
            if (fb) r = r ^ 5'b00101;
        end
        return r;
    endfunction

    // Serial CRC16 (x^16+x^15+x^2+1) unrolled to a byte per cycle, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h8005;
        end
        return r;
    endfunction

    assign rise        = rx_active & ~act_q;
    assign fall        = ~rx_active & act_q;
    // A byte landing in the falling-edge cycle still belongs to the packet.
    assign byte_in     = rx_valid & (rx_active | act_q);
    assign pid_is_data = (rx_data[3:0] == PID_DATA0) || (rx_data[3:0] == PID_DATA1);
    // New packet context is opened whenever we move into PID from outside it.
    assign start       = (state_nxt == S_PID) && ((state != S_PID) || end_pend);
    assign dat_good    = (state == S_DATA) && !err_flag && (cnt >= CNT_TWO) &&
                         (crc16 == 16'h800D);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and per-byte control decode.
    always_comb begin
        state_nxt = state;
        set_err   = 1'b0;
        pid_take  = 1'b0;
        tok_take  = 1'b0;
        dat_take  = 1'b0;
        emit      = 1'b0;
        if (end_pend) begin
            state_nxt = rise ? S_PID : S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (rise) state_nxt = S_PID;
                S_PID: if (byte_in) begin
                    if (rx_data[7:4] != ~rx_data[3:0]) begin
                        set_err   = 1'b1;
                        state_nxt = S_DRAIN;
                    end else begin
                        case (rx_data[3:0])
                            PID_OUT, PID_IN, PID_SETUP, PID_SOF: begin
                                pid_take  = 1'b1;
                                state_nxt = S_TOKEN;
                            end
                            PID_DATA0, PID_DATA1: begin
                                pid_take  = 1'b1;
                                state_nxt = S_DATA;
                            end
                            PID_ACK, PID_NAK, PID_STALL: begin
                                pid_take  = 1'b1;
                                state_nxt = S_HSK;
                            end
                            default: begin
                                set_err   = 1'b1;
                                state_nxt = S_DRAIN;
                            end
                        endcase
                    end
                end
                S_TOKEN: if (byte_in) begin
                    if (cnt == CNT_TWO) begin
                        set_err   = 1'b1;
                        state_nxt = S_DRAIN;
                    end else begin
                        tok_take = 1'b1;
                    end
                end
                S_DATA: if (byte_in) begin
                    if (cnt >= CNT_LIM) begin
                        set_err   = 1'b1;
                        state_nxt = S_DRAIN;
                    end else begin
                        dat_take = 1'b1;
                        emit     = (cnt >= CNT_TWO);
                    end
                end
                S_HSK: if (byte_in) begin
                    set_err   = 1'b1;
                    state_nxt = S_DRAIN;
                end
                S_DRAIN: ;
                default: state_nxt = S_IDLE;
            endcase
            // SIE error overrides whatever the byte would have done.
            if (rx_error && (state != S_IDLE)) begin
                set_err   = 1'b1;
                pid_take  = 1'b0;
                tok_take  = 1'b0;
                dat_take  = 1'b0;
                emit      = 1'b0;
                state_nxt = S_DRAIN;
            end
        end
    end

    // Packet context: edge tracking, counters, CRCs, token bytes, delay line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q    <= 1'b0;
            end_pend <= 1'b0;
            err_flag <= 1'b0;
            is_data  <= 1'b0;
            cnt      <= '0;
            crc5     <= 5'h1F;
            crc16    <= 16'hFFFF;
            b1       <= '0;
            b2       <= '0;
            d0       <= '0;
            d1       <= '0;
        end else begin
            act_q    <= rx_active;
            end_pend <= fall && (state != S_IDLE) && !end_pend;
            if (start) begin
                err_flag <= 1'b0;
                is_data  <= 1'b0;
                cnt      <= '0;
                crc5     <= 5'h1F;
                crc16    <= 16'hFFFF;
            end
            if (set_err) err_flag <= 1'b1;
            if (pid_take && pid_is_data) is_data <= 1'b1;
            if (tok_take) begin
                cnt  <= cnt + CNT_ONE;
                crc5 <= crc5_byte(crc5, rx_data);
                if (cnt == '0) b1 <= rx_data;
                else           b2 <= rx_data[2:0];
            end
            if (dat_take) begin
                cnt   <= cnt + CNT_ONE;
                crc16 <= crc16_byte(crc16, rx_data);
                d1    <= d0;
                d0    <= rx_data;
            end
        end
    end

    // Registered outputs: one-cycle pulses, held PID/endpoint/frame fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pid         <= '0;
            token_valid <= 1'b0;
            token_ep    <= '0;
            sof_valid   <= 1'b0;
            frame_num   <= '0;
            hsk_valid   <= 1'b0;
            data_start  <= 1'b0;
            data_byte   <= '0;
            data_valid  <= 1'b0;
            data_done   <= 1'b0;
            data_ok     <= 1'b0;
            pkt_err     <= 1'b0;
        end else begin
            token_valid <= 1'b0;
            sof_valid   <= 1'b0;
            hsk_valid   <= 1'b0;
            data_start  <= 1'b0;
            data_valid  <= 1'b0;
            data_done   <= 1'b0;
            data_ok     <= 1'b0;
            pkt_err     <= 1'b0;
            if (pid_take) begin
                pid        <= rx_data[3:0];
                data_start <= pid_is_data;
            end
            if (emit) begin
                data_valid <= 1'b1;
                data_byte  <= d1;
            end
            if (end_pend) begin
                if (is_data) begin
                    data_done <= 1'b1;
                    data_ok   <= dat_good;
                    pkt_err   <= !dat_good;
                end else begin
                    case (state)
                        S_TOKEN: begin
                            if ((cnt == CNT_TWO) && (crc5 == 5'b01100)) begin
                                if (pid == PID_SOF) begin
                                    sof_valid <= 1'b1;
                                    frame_num <= {b2, b1};
                                end else if (b1[6:0] == dev_addr) begin
                                    token_valid <= 1'b1;
                                    token_ep    <= {b2, b1[7]};
                                end
                            end else begin
                                pkt_err <= 1'b1;
                            end
                        end
                        S_HSK:   hsk_valid <= 1'b1;
                        default: pkt_err   <= 1'b1;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_pkt_rx.sv
// Directed bench for usb_pkt_rx: table of packets plus hand-written
// sequences for error injection, overlong payload, back-to-back packets
// and reset in the middle of a packet.
module tb_usb_pkt_rx;
    localparam int MAXP = 64;
    localparam int NV   = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_active = 1'b0;
    logic        rx_error = 1'b0;
    logic [6:0]  dev_addr = '0;
    logic [3:0]  pid;
    logic        token_valid;
    logic [3:0]  token_ep;
    logic        sof_valid;
    logic [10:0] frame_num;
    logic        hsk_valid;
    logic        data_start;
    logic [7:0]  data_byte;
    logic        data_valid;
    logic        data_done;
    logic        data_ok;
    logic        pkt_err;

    always #5 clk = ~clk;

    usb_pkt_rx #(.MAX_PAYLOAD(MAXP)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_active(rx_active), .rx_error(rx_error), .dev_addr(dev_addr),
        .pid(pid), .token_valid(token_valid), .token_ep(token_ep),
        .sof_valid(sof_valid), .frame_num(frame_num), .hsk_valid(hsk_valid),
        .data_start(data_start), .data_byte(data_byte), .data_valid(data_valid),
        .data_done(data_done), .data_ok(data_ok), .pkt_err(pkt_err)
    );

    int errors = 0;
    int checks = 0;

    // Pulse monitor: monotonic counters, sampled mid-cycle.
    int n_tok = 0, n_sof = 0, n_hsk = 0, n_start = 0;
    int n_done = 0, n_ok = 0, n_err = 0, n_val = 0;
    logic [7:0] vbytes [0:255];
    logic [3:0] start_pid = '0;
    always @(negedge clk) begin
        if (token_valid) n_tok++;
        if (sof_valid)   n_sof++;
        if (hsk_valid)   n_hsk++;
        if (data_start) begin n_start++; start_pid = pid; end
        if (data_done)  n_done++;
        if (data_done && data_ok) n_ok++;
        if (pkt_err)    n_err++;
        if (data_valid) begin
            if (n_val < 256) vbytes[n_val] = data_byte;
            n_val++;
        end
    end

    typedef struct {
        int               n;
        logic [0:11][7:0] b;
        logic [6:0]       a;
        int               tok, sof, hsk, st, done, ok, err, nval;
        logic [3:0]       epid;
        logic [3:0]       eep;
        logic [10:0]      efr;
    } vec_t;

    vec_t  vt [NV];
    string vnm [NV];
    int    nv = 0;

    logic [7:0] pbuf [0:127];
    int b_tok, b_sof, b_hsk, b_start, b_done, b_ok, b_err, b_val;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic snap();
        b_tok = n_tok; b_sof = n_sof; b_hsk = n_hsk; b_start = n_start;
        b_done = n_done; b_ok = n_ok; b_err = n_err; b_val = n_val;
    endtask

    // Token bytes {b2, b1} for an 11-bit field with generated CRC5.
    function automatic logic [15:0] tok_field(input logic [10:0] f);
        logic [4:0] c;
        logic       fb;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            fb = c[4] ^ f[i];
            c  = {c[3:0], 1'b0};
            if (fb) c = c ^ 5'b00101;
        end
        c = ~c;
        return {c[0], c[1], c[2], c[3], c[4], f[10:8], f[7:0]};
    endfunction

    task automatic addv(input string nm, input int n, input logic [0:11][7:0] b,
                        input logic [6:0] a, input int tok, input int sof, input int hsk,
                        input int st, input int done, input int ok, input int err,
                        input int nval, input logic [3:0] epid, input logic [3:0] eep,
                        input logic [10:0] efr);
        vnm[nv]     = nm;
        vt[nv].n    = n;    vt[nv].b    = b;    vt[nv].a   = a;
        vt[nv].tok  = tok;  vt[nv].sof  = sof;  vt[nv].hsk = hsk;
        vt[nv].st   = st;   vt[nv].done = done; vt[nv].ok  = ok;
        vt[nv].err  = err;  vt[nv].nval = nval;
        vt[nv].epid = epid; vt[nv].eep  = eep;  vt[nv].efr = efr;
        nv++;
    endtask

    // Drive one packet from pbuf; optional rx_error before byte err_at and
    // optional last byte in the rx_active falling cycle.
    task automatic send(input int n, input bit last_on_fall, input int err_at);
        @(negedge clk); rx_active = 1'b1;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            if (k == err_at) begin
                @(negedge clk); rx_error = 1'b1;
                @(negedge clk); rx_error = 1'b0;
            end
            @(negedge clk);
            rx_data  = pbuf[k];
            rx_valid = 1'b1;
            if (last_on_fall && (k == n - 1)) rx_active = 1'b0;
            @(negedge clk);
            rx_valid = 1'b0;
        end
        rx_active = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic chk_counts(input string nm, input int tok, input int sof, input int hsk,
                              input int st, input int done, input int ok, input int err,
                              input int nval);
        chk({nm, ".token_valid"}, n_tok - b_tok, tok);
        chk({nm, ".sof_valid"},   n_sof - b_sof, sof);
        chk({nm, ".hsk_valid"},   n_hsk - b_hsk, hsk);
        chk({nm, ".data_start"},  n_start - b_start, st);
        chk({nm, ".data_done"},   n_done - b_done, done);
        chk({nm, ".data_ok"},     n_ok - b_ok, ok);
        chk({nm, ".pkt_err"},     n_err - b_err, err);
        chk({nm, ".data_valid"},  n_val - b_val, nval);
    endtask

    logic [15:0] t_in, t_sof;
    int bad;

    initial begin
        t_in  = tok_field({4'h5, 7'h3A});
        t_sof = tok_field(11'h123);
        //    name          n  bytes                                                          addr    tk sf hk st dn ok er nv pid    ep     frame
        addv("setup_ok",    3, {8'h2D, 8'h00, 8'h10, 72'h0},                                   7'h00,  1, 0, 0, 0, 0, 0, 0, 0, 4'hD, 4'h0, 11'h000);
        addv("setup_mis",   3, {8'h2D, 8'h00, 8'h10, 72'h0},                                   7'h05,  0, 0, 0, 0, 0, 0, 0, 0, 4'hD, 4'h0, 11'h000);
        addv("setup_crc",   3, {8'h2D, 8'h00, 8'h11, 72'h0},                                   7'h00,  0, 0, 0, 0, 0, 0, 1, 0, 4'hD, 4'h0, 11'h000);
        addv("in_ep5",      3, {8'h69, t_in[7:0], t_in[15:8], 72'h0},                          7'h3A,  1, 0, 0, 0, 0, 0, 0, 0, 4'h9, 4'h5, 11'h000);
        addv("sof",         3, {8'hA5, t_sof[7:0], t_sof[15:8], 72'h0},                        7'h3A,  0, 1, 0, 0, 0, 0, 0, 0, 4'h5, 4'h5, 11'h123);
        addv("in_extra",    4, {8'h69, t_in[7:0], t_in[15:8], 8'h00, 64'h0},                   7'h3A,  0, 0, 0, 0, 0, 0, 1, 0, 4'h9, 4'h5, 11'h123);
        addv("data0_ok",   11, {8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94, 8'h00},
                                                                                                7'h00,  0, 0, 0, 1, 1, 1, 0, 8, 4'h3, 4'h5, 11'h123);
        addv("data0_bad",  11, {8'hC3, 8'h81, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94, 8'h00},
                                                                                                7'h00,  0, 0, 0, 1, 1, 0, 1, 8, 4'h3, 4'h5, 11'h123);
        addv("data1_zlp",   3, {8'h4B, 8'h00, 8'h00, 72'h0},                                   7'h00,  0, 0, 0, 1, 1, 1, 0, 0, 4'hB, 4'h5, 11'h123);
        addv("ack",         1, {8'hD2, 88'h0},                                                 7'h00,  0, 0, 1, 0, 0, 0, 0, 0, 4'h2, 4'h5, 11'h123);
        addv("bad_pid",     3, {8'h2C, 8'h00, 8'h10, 72'h0},                                   7'h00,  0, 0, 0, 0, 0, 0, 1, 0, 4'h2, 4'h5, 11'h123);
        addv("nak_extra",   2, {8'h5A, 8'h00, 80'h0},                                          7'h00,  0, 0, 0, 0, 0, 0, 1, 0, 4'hA, 4'h5, 11'h123);
        addv("unknown_pid", 1, {8'hF0, 88'h0},                                                 7'h00,  0, 0, 0, 0, 0, 0, 1, 0, 4'hA, 4'h5, 11'h123);
        addv("data_short",  2, {8'hC3, 8'h00, 80'h0},                                          7'h00,  0, 0, 0, 1, 1, 0, 1, 0, 4'h3, 4'h5, 11'h123);
        addv("token_short", 2, {8'h69, 8'hBA, 80'h0},                                          7'h3A,  0, 0, 0, 0, 0, 0, 1, 0, 4'h9, 4'h5, 11'h123);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset.pid", int'(pid), 0);
        chk("reset.token_ep", int'(token_ep), 0);
        chk("reset.frame_num", int'(frame_num), 0);
        chk("reset.data_byte", int'(data_byte), 0);
        chk("reset.pulses", int'({token_valid, sof_valid, hsk_valid, data_start,
                                   data_valid, data_done, data_ok, pkt_err}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven packets
        for (int i = 0; i < nv; i++) begin
            dev_addr = vt[i].a;
            for (int k = 0; k < 12; k++) pbuf[k] = vt[i].b[k];
            snap();
            send(vt[i].n, 1'b0, -1);
            chk_counts(vnm[i], vt[i].tok, vt[i].sof, vt[i].hsk, vt[i].st, vt[i].done,
                       vt[i].ok, vt[i].err, vt[i].nval);
            chk({vnm[i], ".pid"}, int'(pid), int'(vt[i].epid));
            chk({vnm[i], ".token_ep"}, int'(token_ep), int'(vt[i].eep));
            chk({vnm[i], ".frame_num"}, int'(frame_num), int'(vt[i].efr));
            if (vt[i].st != 0) chk({vnm[i], ".start_pid"}, int'(start_pid), int'(vt[i].epid));
            if (vt[i].nval != 0) begin
                bad = 0;
                for (int k = 0; k < vt[i].nval; k++)
                    if ((b_val + k > 255) || (vbytes[b_val + k] != vt[i].b[k + 1])) bad++;
                chk({vnm[i], ".payload_bytes_wrong"}, bad, 0);
            end
        end

        // rx_active pulse with no byte in PID state
        snap();
        @(negedge clk); rx_active = 1'b1;
        repeat (2) @(negedge clk); rx_active = 1'b0;
        repeat (6) @(negedge clk);
        chk_counts("pid_empty", 0, 0, 0, 0, 0, 0, 1, 0);

        // rx_error in the middle of a DATA packet
        pbuf[0] = 8'hC3; pbuf[1] = 8'h80; pbuf[2] = 8'h06; pbuf[3] = 8'h00;
        snap();
        send(4, 1'b0, 3);
        chk_counts("rx_error", 0, 0, 0, 1, 1, 0, 1, 0);

        // 65 payload bytes: 64 emitted, then rejected
        pbuf[0] = 8'hC3;
        for (int k = 1; k <= 65; k++) pbuf[k] = 8'(k);
        pbuf[66] = 8'h00; pbuf[67] = 8'h00;
        snap();
        send(68, 1'b0, -1);
        chk_counts("overlong", 0, 0, 0, 1, 1, 0, 1, 64);
        bad = 0;
        for (int k = 0; k < 64; k++)
            if ((b_val + k > 255) || (vbytes[b_val + k] != pbuf[k + 1])) bad++;
        chk("overlong.payload_bytes_wrong", bad, 0);

        // Last CRC byte delivered in the rx_active falling cycle
        pbuf[0] = 8'h4B; pbuf[1] = 8'h00; pbuf[2] = 8'h00;
        snap();
        send(3, 1'b1, -1);
        chk_counts("zlp_on_fall", 0, 0, 0, 1, 1, 1, 0, 0);

        // Second packet starts while the first is still being evaluated
        snap();
        @(negedge clk); rx_active = 1'b1;
        @(negedge clk);
        @(negedge clk); rx_data = 8'hD2; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        @(negedge clk); rx_active = 1'b0;
        @(negedge clk); rx_active = 1'b1;
        @(negedge clk); rx_data = 8'h5A; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        @(negedge clk); rx_active = 1'b0;
        repeat (6) @(negedge clk);
        chk_counts("back_to_back", 0, 0, 2, 0, 0, 0, 0, 0);
        chk("back_to_back.pid", int'(pid), 4'hA);

        // Reset after two bytes of a token
        dev_addr = 7'h00;
        snap();
        @(negedge clk); rx_active = 1'b1;
        @(negedge clk);
        @(negedge clk); rx_data = 8'h2D; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        @(negedge clk); rx_data = 8'h00; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst.pid", int'(pid), 0);
        chk("mid_rst.token_ep", int'(token_ep), 0);
        chk("mid_rst.frame_num", int'(frame_num), 0);
        @(negedge clk); rx_active = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_counts("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        pbuf[0] = 8'h2D; pbuf[1] = 8'h00; pbuf[2] = 8'h10;
        snap();
        send(3, 1'b0, -1);
        chk_counts("after_rst", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("after_rst.pid", int'(pid), 4'hD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_pkt_rx.md
Name: usb_pkt_rx

Overview:
- Packet decoder sitting directly downstream of the SIE receive side. Consumes its byte stream (rx_data/rx_valid/rx_active/rx_error).
- Checks the PID, parses token/SOF fields and verifies CRC5/CRC16.
- Streams data payload with the CRC bytes stripped, and reports handshakes, end-of-packet status and errors to the protocol engine.

Parameters:
- MAX_PAYLOAD, 64, max data payload bytes accepted (excluding PID and CRC16); longer packet -> error.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  8  byte from SIE rx, LSB = first bit on wire
- rx_valid  in  1  one-cycle pulse, rx_data valid
- rx_active  in  1  SIE receive active (packet envelope)
- rx_error  in  1  SIE receive error (bit-stuff violation)
- dev_addr  in  7  current device address for token match
- pid  out  4  PID of last accepted packet
- token_valid  out  1  pulse: OUT/IN/SETUP token to dev_addr, CRC5 good
- token_ep  out  4  token endpoint
- sof_valid  out  1  pulse: SOF received, CRC5 good
- frame_num  out  11  SOF frame number
- hsk_valid  out  1  pulse: ACK/NAK/STALL received
- data_start  out  1  pulse: DATA0/DATA1 PID accepted (pid already updated)
- data_byte  out  8  payload byte
- data_valid  out  1  pulse: data_byte valid
- data_done  out  1  pulse: data packet ended
- data_ok  out  1  qualifies data_done: CRC16 residual good, length legal, no error
- pkt_err  out  1  pulse: any packet rejected (PID check, CRC5, length, rx_error, unknown PID)

Behaviour:
- Reset: all outputs 0; FSM IDLE; byte counter 0; CRC5 = 5'h1F, CRC16 = 16'hFFFF; payload delay line empty.
- FSM states: IDLE, PID, TOKEN, DATA, HSK, DRAIN.
- IDLE -> PID on rx_active rising.
- PID: first rx_valid byte.
  - Require rx_data[7:4] == ~rx_data[3:0]; else -> DRAIN with error flag.
  - Decode pid = rx_data[3:0]:
    - OUT 0001, IN 1001, SETUP 1101, SOF 0101 -> TOKEN.
    - DATA0 0011, DATA1 1011 -> DATA; pulse data_start next cycle.
    - ACK 0010, NAK 1010, STALL 1110 -> HSK.
    - Others -> DRAIN with error.
- TOKEN: capture exactly 2 bytes b1, b2.
  - addr = b1[6:0]; ep = {b2[2:0], b1[7]}; frame = {b2[2:0], b1}.
  - CRC5 (poly x^5+x^2+1, init 1F) runs over all 16 bits LSB-first; residual must equal 5'b01100.
  - A third byte -> error.
- DATA: each byte updates CRC16 (poly x^16+x^15+x^2+1, init FFFF, LSB-first, 8-bit parallel in one cycle).
  - Bytes pass through a 2-deep delay line. data_valid/data_byte emitted for a byte only once two later bytes have arrived, so CRC bytes are never emitted.
  - Payload count > MAX_PAYLOAD -> error; stop emitting.
- HSK: any further byte -> error.
- DRAIN: ignore bytes until rx_active low.
- rx_error high in any non-IDLE state -> error flag set; state -> DRAIN.
- End of packet: rx_active 1->0 detected. Status is evaluated on the following cycle, so a byte with rx_valid in the falling-edge cycle is processed first. All end pulses are registered and last 1 cycle; state then returns to IDLE.
  - TOKEN: 2 bytes and residual ok.
    - SOF: sof_valid, frame_num updated.
    - OUT/IN/SETUP with addr == dev_addr: token_valid, token_ep updated.
    - Address mismatch: silent drop, no pulse.
    - Otherwise: pkt_err.
  - DATA: data_done always pulses.
    - data_ok = residual == 16'h800D AND total bytes >= 2 AND no error flag.
    - When data_ok = 0, pkt_err also pulses.
  - HSK with exactly 1 byte: hsk_valid; else pkt_err.
  - Error flag set or PID failed: pkt_err only.
  - rx_active falling in PID state with no byte received: pkt_err.
- pid register updates only on a PID byte that passes the check; token_ep/frame_num hold between packets.
- Bytes arriving while rx_active = 0 are ignored.
- rx_active re-rising while an end evaluation is pending: evaluation completes first; the new packet starts in PID.
- Async reset mid-packet: immediate return to reset state, no pulses.

Test Plan:
- dev_addr=0; bytes 2D 00 10 then rx_active low -> token_valid=1 one cycle, pid=1101, token_ep=0; no pkt_err.
- Same token with dev_addr=5 -> no token_valid, no pkt_err.
- Same token with last byte corrupted to 11 (bad CRC5) -> pkt_err=1 only.
- DATA0: C3 80 06 00 01 00 00 40 00 DD 94 -> data_start, 8 data_valid pulses 80,06,00,01,00,00,40,00, then data_done=1, data_ok=1.
- Same packet with one payload byte flipped -> data_done=1, data_ok=0, pkt_err=1.
- Zero-length DATA1: 4B 00 00 -> data_done, data_ok=1, 0 data_valid.
- Single D2 -> hsk_valid, pid=0010.
- PID byte 2C -> pkt_err; subsequent bytes ignored.
- rx_error mid-DATA -> data_done with data_ok=0, pkt_err.
- MAX_PAYLOAD=64 with 65 payload bytes -> data_ok=0; exactly 64 emitted.
- Assert rst after 2 bytes of a token -> all outputs 0 immediately; next packet decodes normally.
